// File: rtl/floo_vc_input_buffer_if.sv
// Link-side and router-side signals of the per-VC input buffer.
// The buffer uses the slave modport and the upstream link/router side uses master.
interface floo_vc_input_buffer_if #(
    parameter int unsigned NumVC         = 5,
    parameter int unsigned VCIdxWidthMax = 3,
    parameter int unsigned FlitWidth     = 64
);
    logic                                valid_i;
    logic [VCIdxWidthMax-1:0]            vc_id_i;
    logic [FlitWidth-1:0]                data_i;
    logic [NumVC-1:0]                    valid_o;
    logic [NumVC-1:0][FlitWidth-1:0]     data_o;
    logic [NumVC-1:0]                    ready_i;
    logic                                credit_valid_o;
    logic [VCIdxWidthMax-1:0]            credit_id_o;
    logic                                overflow_o;

    modport master (
        output valid_i, vc_id_i, data_i, ready_i,
        input  valid_o, data_o, credit_valid_o, credit_id_o, overflow_o
    );

    modport slave (
        input  valid_i, vc_id_i, data_i, ready_i,
        output valid_o, data_o, credit_valid_o, credit_id_o, overflow_o
    );
endinterface

// File: rtl/floo_vc_input_buffer.sv
// Router input port: one FIFO per virtual channel, with dequeued slots returned
// upstream as credits over a single round-robin serialized credit link.
module floo_vc_input_buffer #(
    parameter int unsigned NumVC         = 5,
    parameter int unsigned VCIdxWidthMax = 3,
    parameter int unsigned VCDepth       = 2,
    parameter int unsigned DeeperVCId    = 0,
    parameter int unsigned DeeperVCDepth = 2,
    parameter int unsigned FlitWidth     = 64,
    parameter int unsigned VCIdxWidth    = (NumVC > 1) ? $clog2(NumVC) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    floo_vc_input_buffer_if.slave  bus
);

    localparam int unsigned MaxDepth = (DeeperVCDepth > VCDepth) ? DeeperVCDepth : VCDepth;
    localparam int unsigned CntWidth = $clog2(MaxDepth + 1);
    localparam int unsigned PtrWidth = (MaxDepth > 1) ? $clog2(MaxDepth) : 1;
    localparam logic [VCIdxWidth:0] NumVCExt = (VCIdxWidth + 1)'(NumVC);

    typedef logic [CntWidth-1:0]   cnt_t;
    typedef logic [PtrWidth-1:0]   ptr_t;
    typedef logic [VCIdxWidth-1:0] vc_idx_t;
    typedef logic [FlitWidth-1:0]  flit_t;

    function automatic cnt_t vc_depth(input int unsigned vc);
        cnt_t depth;
        if (vc == DeeperVCId) begin
            depth = CntWidth'(DeeperVCDepth);
        end else begin
            depth = CntWidth'(VCDepth);
        end
        return depth;
    endfunction

    // Ring pointer arithmetic; each VC wraps at its own depth.
    function automatic ptr_t ptr_add(input ptr_t base, input cnt_t offs, input int unsigned vc);
        logic [CntWidth:0] sum;
        sum = (CntWidth + 1)'(base) + (CntWidth + 1)'(offs);
        if (sum >= (CntWidth + 1)'(vc_depth(vc))) begin
            sum = sum - (CntWidth + 1)'(vc_depth(vc));
        end else begin
            sum = sum;
        end
        return PtrWidth'(sum);
    endfunction

    function automatic vc_idx_t rr_offset(input vc_idx_t base, input int unsigned offs);
        int unsigned sum;
        sum = 32'(base) + offs;
        if (sum >= NumVC) begin
            sum = sum - NumVC;
        end else begin
            sum = sum;
        end
        return vc_idx_t'(sum);
    endfunction

    flit_t                    mem_q [NumVC][MaxDepth];
    flit_t                    mem_d [NumVC][MaxDepth];
    ptr_t                     head_q [NumVC];
    ptr_t                     head_d [NumVC];
    cnt_t                     count_q [NumVC];
    cnt_t                     count_d [NumVC];
    cnt_t                     pending_q [NumVC];
    cnt_t                     pending_d [NumVC];
    vc_idx_t                  rr_q, rr_d;
    logic                     credit_valid_q, credit_valid_d;
    logic [VCIdxWidthMax-1:0] credit_id_q, credit_id_d;
    logic                     overflow_q, overflow_d;

    vc_idx_t          in_vc_s;
    logic             in_vc_ok_s;
    logic [NumVC-1:0] sel_s, full_s, push_s, pop_s, req_s, grant_s;
    ptr_t             tail_s [NumVC];
    logic             grant_found_s;
    vc_idx_t          grant_idx_s;

    // Decode the incoming flit and per-VC push/pop qualifiers from cycle-start state.
    always_comb begin
        in_vc_s    = bus.vc_id_i[VCIdxWidth-1:0];
        in_vc_ok_s = ({1'b0, in_vc_s} < NumVCExt);
        for (int v = 0; v < NumVC; v++) begin
            sel_s[v]  = bus.valid_i & in_vc_ok_s & (in_vc_s == vc_idx_t'(v));
            full_s[v] = (count_q[v] == vc_depth(v));
            push_s[v] = sel_s[v] & ~full_s[v];
            pop_s[v]  = (count_q[v] != '0) & bus.ready_i[v];
            tail_s[v] = ptr_add(head_q[v], count_q[v], v);
        end
    end

    // FIFO storage, pointers and the sticky overflow flag.
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        count_d = count_q;
        for (int v = 0; v < NumVC; v++) begin
            if (push_s[v]) begin
                mem_d[v][tail_s[v]] = bus.data_i;
            end else begin
                mem_d[v] = mem_q[v];
            end
            if (pop_s[v]) begin
                head_d[v] = ptr_add(head_q[v], CntWidth'(1), v);
            end else begin
                head_d[v] = head_q[v];
            end
            count_d[v] = count_q[v] + CntWidth'(push_s[v]) - CntWidth'(pop_s[v]);
        end
        // A full VC rejects even when it pops this cycle: upstream overspent its credits.
        overflow_d = overflow_q | (bus.valid_i & (~in_vc_ok_s | (|(sel_s & full_s))));
    end

    // Round-robin credit arbiter; a fresh pop can be returned in the same cycle.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = rr_q;
        grant_s       = '0;
        for (int v = 0; v < NumVC; v++) begin
            req_s[v] = (pending_q[v] != '0) | pop_s[v];
        end
        for (int k = 0; k < NumVC; k++) begin
            if (!grant_found_s && req_s[rr_offset(rr_q, k)]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = rr_offset(rr_q, k);
            end else begin
                grant_found_s = grant_found_s;
            end
        end
        if (grant_found_s) begin
            grant_s[grant_idx_s] = 1'b1;
            rr_d                 = rr_offset(grant_idx_s, 1);
            credit_id_d          = '0;
            credit_id_d[VCIdxWidth-1:0] = grant_idx_s;
        end else begin
            grant_s     = '0;
            rr_d        = rr_q;
            credit_id_d = credit_id_q;
        end
        credit_valid_d = grant_found_s;
        for (int v = 0; v < NumVC; v++) begin
            pending_d[v] = pending_q[v] + CntWidth'(pop_s[v]) - CntWidth'(grant_s[v]);
        end
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_q         <= '{default: '0};
            count_q        <= '{default: '0};
            pending_q      <= '{default: '0};
            rr_q           <= '0;
            credit_valid_q <= 1'b0;
            credit_id_q    <= '0;
            overflow_q     <= 1'b0;
        end else begin
            head_q         <= head_d;
            count_q        <= count_d;
            pending_q      <= pending_d;
            rr_q           <= rr_d;
            credit_valid_q <= credit_valid_d;
            credit_id_q    <= credit_id_d;
            overflow_q     <= overflow_d;
        end
    end

    // Flit storage needs no reset; occupancy gates visibility.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    // Outputs come straight from registered state, so there is no fall-through path.
    always_comb begin
        for (int v = 0; v < NumVC; v++) begin
            bus.valid_o[v] = (count_q[v] != '0);
            bus.data_o[v]  = mem_q[v][head_q[v]];
        end
        bus.credit_valid_o = credit_valid_q;
        bus.credit_id_o    = credit_id_q;
        bus.overflow_o     = overflow_q;
    end

endmodule
